tug_of_war_field: RTL

- Parametrised next-generation tug-of-war playfield.
- A single lit position moves along a row of `NUM_LIGHTS` LEDs in response to left/right player presses.
- Scores rounds per player, inserts a dark serve interval between rounds, and declares a match winner after `WIN_ROUNDS` points.
- Sits between the player-input conditioning (synchronised, debounced keys) and the LEDR/HEX display drivers at the top level.

---
 rtl/tug_of_war_field.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield: one lit LED pulled left/right by player presses, with rounds, serve gaps and a match winner.
// Optional build macro TOW_EDGE_DETECT_EN turns keys into one-shot presses; when undefined, held keys act every cycle.
module tug_of_war_field #(
    parameter int NUM_LIGHTS   = 9,
    parameter int WIN_ROUNDS   = 7,
    parameter int SERVE_CYCLES = 4,
    localparam int SW          = $clog2(WIN_ROUNDS + 1)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  L,
    input  logic                  R,
    output logic [NUM_LIGHTS:1]   lights,
    output logic [SW-1:0]         leftScore,
    output logic [SW-1:0]         rightScore,
    output logic [1:0]            pointWinner,
    output logic [1:0]            matchWinner
);
    localparam int PW = $clog2(NUM_LIGHTS + 1);
    localparam int CW = $clog2(SERVE_CYCLES + 1);
    localparam int C  = (NUM_LIGHTS + 1) / 2;
    localparam logic [PW-1:0]       POS_C    = PW'(C);
    localparam logic [PW-1:0]       POS_MAX  = PW'(NUM_LIGHTS);
    localparam logic [PW-1:0]       POS_MIN  = PW'(1);
    localparam logic [NUM_LIGHTS:1] LIGHTS_1 = NUM_LIGHTS'(1);
    localparam logic [NUM_LIGHTS:1] LIGHTS_C = LIGHTS_1 << (C - 1);

    typedef enum logic [1:0] {PLAY, SERVE, DONE} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         pos_q, pos_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         left_q, left_d, right_q, right_d;
    logic [1:0]            pw_q, pw_d, mw_q, mw_d;
    logic [NUM_LIGHTS:1]   lights_q, lights_d;
    logic                  pl, pr, press_l, press_r;

`ifdef TOW_EDGE_DETECT_EN
    logic lprev_q, rprev_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            lprev_q <= 1'b0;
            rprev_q <= 1'b0;
        end else begin
            lprev_q <= L;
            rprev_q <= R;
        end
    end

    assign pl = L & ~lprev_q;
    assign pr = R & ~rprev_q;
`else
    assign pl = L;
    assign pr = R;
`endif

    // Both players pressing together cancels out.
    assign press_l = pl & ~pr;
    assign press_r = pr & ~pl;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        right_d = right_q;
        pw_d    = pw_q;
        mw_d    = mw_q;
        case (state_q)
            PLAY: begin
                if (press_l) begin
                    if (pos_q == POS_MAX) begin
                        left_d = left_q + SW'(1);
                        pw_d   = 2'b01;
                        if (int'(left_q) + 1 == WIN_ROUNDS) begin
                            state_d = DONE;
                            mw_d    = 2'b01;
                        end else begin
                            state_d = SERVE;
                            cnt_d   = CW'(SERVE_CYCLES - 1);
                        end
                    end else begin
                        pos_d = pos_q + PW'(1);
                    end
                end else if (press_r) begin
                    if (pos_q == POS_MIN) begin
                        right_d = right_q + SW'(1);
                        pw_d    = 2'b10;
                        if (int'(right_q) + 1 == WIN_ROUNDS) begin
                            state_d = DONE;
                            mw_d    = 2'b10;
                        end else begin
                            state_d = SERVE;
                            cnt_d   = CW'(SERVE_CYCLES - 1);
                        end
                    end else begin
                        pos_d = pos_q - PW'(1);
                    end
                end
            end
            SERVE: begin
                if (cnt_q == '0) begin
                    state_d = PLAY;
                    pos_d   = POS_C;
                    pw_d    = 2'b00;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: ;
        endcase
        // Decode the next position here so the LED row comes straight from a flop.
        lights_d = (state_d == PLAY) ? (LIGHTS_1 << (pos_d - POS_MIN)) : '0;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= PLAY;
            pos_q    <= POS_C;
            cnt_q    <= '0;
            left_q   <= '0;
            right_q  <= '0;
            pw_q     <= 2'b00;
            mw_q     <= 2'b00;
            lights_q <= LIGHTS_C;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            right_q  <= right_d;
            pw_q     <= pw_d;
            mw_q     <= mw_d;
            lights_q <= lights_d;
        end
    end

    assign lights      = lights_q;
    assign leftScore   = left_q;
    assign rightScore  = right_q;
    assign pointWinner = pw_q;
    assign matchWinner = mw_q;
endmodule
